window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage.
- Accepts one signed pixel per valid cycle in raster order, buffers two previous image rows, and emits a full 9-pixel neighbourhood in the convolution's data_i[9] format.
- Uses "valid" convolution, with no padding: one window per input pixel at row >= 2 and col >= 2.

Parameters:
DATA_WIDTH, 8, pixel width in bits (signed)
IMG_WIDTH, 32, pixels per row; legal range >= 3
IMG_HEIGHT, 32, rows per frame; legal range >= 3

Ports:
clk  input  1  clock; all logic is on posedge
rst  input  1  synchronous, active-high reset
valid_i  input  1  data_i carries a pixel this cycle
data_i  input  signed [DATA_WIDTH-1:0]  pixel, raster order (row-major, left to right)
valid_o  output  1  data_o holds a new window, one-cycle pulse per window
data_o  output  signed [DATA_WIDTH-1:0] [9] (unpacked)  window, index = 3*dy + dx; [0] is top-left (row r-2, col c-2), [8] is bottom-right (current pixel r, c)

Behaviour:
- Counters:
  - col_cnt runs 0..IMG_WIDTH-1; row_cnt runs 0..IMG_HEIGHT-1.
  - Both advance only on valid_i=1.
  - col_cnt wraps to 0 and increments row_cnt. Both wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - The next frame starts on the next valid pixel, with no gap required.
- Line buffers:
  - Two row buffers, each IMG_WIDTH deep (inferred RAM or shift registers).
  - On each valid_i: lb1[col] <= lb0[col] and lb0[col] <= data_i.
  - The read of a location precedes its write in the same cycle.
- Window registers:
  - 3x3 register array. On valid_i, each row shifts left by one column.
  - The new right column is {lb1[col], lb0[col], data_i}, i.e. rows r-2, r-1, r.
- Output:
  - valid_o <= valid_i && row_cnt >= 2 && col_cnt >= 2, evaluated on the accepting edge.
  - data_o is driven from the window registers, so the window appears in the cycle after the pixel that completes it is accepted. Latency is 1 cycle.
  - Windows never span a row wrap, because col_cnt >= 2 excludes columns 0 and 1.
- Throughput: one window per accepted pixel, with (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. There is no backpressure; the consumer must accept every pulse.
- Bubbles: valid_i=0 shifts nothing and advances no counter. valid_o=0 on the next cycle and data_o holds its last value.
- Reset:
  - col_cnt, row_cnt, valid_o, data_o[0..8] and the window registers all go to 0.
  - Line buffer contents are not cleared; they are don't-care because rows 0 and 1 never emit.
  - Reset mid-frame discards the partial frame. The first valid pixel after reset is treated as (0,0).
- Arithmetic: pure data movement; no width change, no sign modification.

Optional Feature:
- Macro: WINDOW_FRAME_FLAGS_EN
- When defined, the block adds output ports sof_o (1 bit) and eof_o (1 bit), both registered and aligned with valid_o.
  - sof_o=1 with the first window of a frame (input pixel row 2, col 2).
  - eof_o=1 with the last window (input pixel row IMG_HEIGHT-1, col IMG_WIDTH-1).
  - Both reset to 0.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
1. IMG_WIDTH=5, IMG_HEIGHT=4; continuous frame with pixel = 10*r + c.
   - Exactly 6 valid_o pulses.
   - First pulse is 1 cycle after pixel 22 is accepted, with data_o = {0,1,2,10,11,12,20,21,22}.
   - Last pulse has data_o = {12,13,14,22,23,24,32,33,34}.
2. Same frame with random valid_i gaps of 0-3 cycles.
   - Identical 6 windows in the same order.
   - valid_o is never high unless valid_i was high on the previous cycle.
   - data_o is stable during gaps.
3. Two frames back to back, no gap: 12 windows. The second frame's windows equal the first frame's, and no window mixes pixels from both frames.
4. Assert rst for 1 cycle after 8 pixels of a frame, then send a full frame: valid_o stays 0 during and after reset until pixel 22, then exactly 6 correct windows.
5. Signed extremes: pixels alternating -128 and 127 propagate bit-exact into data_o, with no sign change.
6. With WINDOW_FRAME_FLAGS_EN defined, run scenario 1: sof_o high only with window {0..22}; eof_o high only with the window ending at 34; each fires once per frame.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two row buffers feed a 3x3 register array.
// Define WINDOW_FRAME_FLAGS_EN to add the sof_o/eof_o frame markers.
module window_3x3_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   output logic                         valid_o,
   output logic signed [DATA_WIDTH-1:0] data_o [9]
`ifdef WINDOW_FRAME_FLAGS_EN
   ,
   output logic                         sof_o,
   output logic                         eof_o
`endif
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          col_last, row_last, win_ok;
   logic          valid_q;

   logic signed [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
   logic signed [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
   logic signed [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
   logic signed [DATA_WIDTH-1:0] win_q [9];
   logic signed [DATA_WIDTH-1:0] win_d [9];

   assign col_last = (col_q == CW'(IMG_WIDTH - 1));
   assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
   assign win_ok   = valid_i && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign lb0_rd   = lb0_q[col_q];
   assign lb1_rd   = lb1_q[col_q];

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_i) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // New right column holds rows r-2, r-1, r at the current column
   always_comb begin
      for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
      if (valid_i) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = lb1_rd;
         win_d[5] = lb0_rd;
         win_d[8] = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= win_ok;
         for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
   end

   // Line buffers are never cleared; rows 0 and 1 refill them before use
   always_ff @(posedge clk) begin
      if (valid_i) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = win_q;

`ifdef WINDOW_FRAME_FLAGS_EN
   logic sof_q, eof_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sof_q <= 1'b0;
         eof_q <= 1'b0;
      end else begin
         sof_q <= valid_i && (row_q == RW'(2)) && (col_q == CW'(2));
         eof_q <= valid_i && row_last && col_last;
      end
   end

   assign sof_o = sof_q;
   assign eof_o = eof_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x4 image.
// Frame flag checks are built when WINDOW_FRAME_FLAGS_EN is defined.
module tb_window_3x3_gen;
   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 4;
   localparam int NW = (W - 2) * (H - 2);

   typedef logic [9*DW-1:0] wp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 valid_i = 1'b0;
   logic signed [DW-1:0] data_i = '0;
   logic                 valid_o;
   logic signed [DW-1:0] data_o [9];
`ifdef WINDOW_FRAME_FLAGS_EN
   logic                 sof_o, eof_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   window_3x3_gen #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .valid_i(valid_i),
      .data_i (data_i),
      .valid_o(valid_o),
      .data_o (data_o)
`ifdef WINDOW_FRAME_FLAGS_EN
      ,
      .sof_o  (sof_o),
      .eof_o  (eof_o)
`endif
   );

   wp_t wq[$];
   int  pq[$];
   bit  sq[$];
   bit  eq[$];
   int  pix_cnt = 0;
   bit  v_edge, r_edge;
   wp_t snap, last_snap;
   int  order_err = 0;
   int  stab_err  = 0;
   int  flag_err  = 0;

   function automatic wp_t pack_o();
      wp_t p;
      for (int k = 0; k < 9; k++) p[k*DW +: DW] = data_o[k];
      return p;
   endfunction

   function automatic logic signed [DW-1:0] pix(input int kind, input int r, input int c);
      int idx;
      idx = r * W + c;
      if (kind == 0) return DW'(10 * r + c);
      return (idx % 2) ? DW'(127) : DW'(-128);
   endfunction

   function automatic wp_t exp_win(input int kind, input int n);
      wp_t p;
      int  r, c;
      r = 2 + n / (W - 2);
      c = 2 + n % (W - 2);
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++)
            p[(3*dy+dx)*DW +: DW] = pix(kind, r - 2 + dy, c - 2 + dx);
      return p;
   endfunction

   function automatic wp_t pack_list(input int v [9]);
      wp_t p;
      for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(v[k]);
      return p;
   endfunction

   always @(posedge clk) begin
      v_edge <= valid_i;
      r_edge <= rst;
      if (rst) pix_cnt <= 0;
      else if (valid_i) pix_cnt <= pix_cnt + 1;
   end

   // Records every window pulse and flags protocol violations
   always @(negedge clk) begin
      snap = pack_o();
      if (valid_o) begin
         wq.push_back(snap);
         pq.push_back(pix_cnt);
         if (!v_edge) order_err++;
`ifdef WINDOW_FRAME_FLAGS_EN
         sq.push_back(sof_o);
         eq.push_back(eof_o);
`endif
      end
`ifdef WINDOW_FRAME_FLAGS_EN
      if (!valid_o && (sof_o || eof_o)) flag_err++;
`endif
      if (!v_edge && !r_edge && snap !== last_snap) stab_err++;
      last_snap = snap;
   end

   task automatic clear_q();
      wq.delete();
      pq.delete();
      sq.delete();
      eq.delete();
      order_err = 0;
      stab_err  = 0;
      flag_err  = 0;
   endtask

   task automatic send(input logic signed [DW-1:0] p);
      valid_i = 1'b1;
      data_i  = p;
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input int kind, input bit gaps);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            send(pix(kind, r, c));
            if (gaps) idle(((r * W + c) * 7 + 3) % 4);
         end
   endtask

   task automatic check_windows(input string nm, input int kind, input int n);
      wp_t got;
      n_cmp++;
      if (wq.size() !== n) begin
         n_err++;
         $display("FAIL %s count: got %0d want %0d", nm, wq.size(), n);
      end
      for (int i = 0; i < n; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         n_cmp++;
         if (got !== exp_win(kind, i % NW)) begin
            n_err++;
            $display("FAIL %s win%0d: got %h want %h", nm, i, got, exp_win(kind, i % NW));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_i = 1'b0;
      idle(2);
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset valid_o: got %b want 0", valid_o);
      end
      n_cmp++;
      if (pack_o() !== '0) begin
         n_err++;
         $display("FAIL reset data_o: got %h want 0", pack_o());
      end
`ifdef WINDOW_FRAME_FLAGS_EN
      n_cmp++;
      if ({sof_o, eof_o} !== 2'b00) begin
         n_err++;
         $display("FAIL reset flags: got %b want 00", {sof_o, eof_o});
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_continuous();
      int  first [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
      int  last  [9] = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
      wp_t got;
      clear_q();
      send_frame(0, 1'b0);
      idle(3);
      check_windows("cont", 0, NW);
      got = (wq.size() > 0) ? wq[0] : 'x;
      n_cmp++;
      if (got !== pack_list(first)) begin
         n_err++;
         $display("FAIL cont first: got %h want %h", got, pack_list(first));
      end
      got = (wq.size() > 0) ? wq[wq.size()-1] : 'x;
      n_cmp++;
      if (got !== pack_list(last)) begin
         n_err++;
         $display("FAIL cont last: got %h want %h", got, pack_list(last));
      end
      n_cmp++;
      if (pq.size() == 0 || pq[0] !== 13) begin
         n_err++;
         $display("FAIL cont latency: got %0d want 13", (pq.size() > 0) ? pq[0] : -1);
      end
   endtask

   task automatic test_gaps();
      clear_q();
      send_frame(0, 1'b1);
      idle(3);
      check_windows("gaps", 0, NW);
      n_cmp++;
      if (order_err !== 0) begin
         n_err++;
         $display("FAIL gaps valid_o w/o valid_i: got %0d want 0", order_err);
      end
      n_cmp++;
      if (stab_err !== 0) begin
         n_err++;
         $display("FAIL gaps data_o stable: got %0d changes want 0", stab_err);
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      send_frame(0, 1'b0);
      send_frame(0, 1'b0);
      idle(3);
      check_windows("b2b", 0, 2 * NW);
   endtask

   task automatic test_reset_midframe();
      clear_q();
      for (int i = 0; i < 8; i++) send(pix(0, i / W, i % W));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      n_cmp++;
      if (wq.size() !== 0) begin
         n_err++;
         $display("FAIL rstmid early pulses: got %0d want 0", wq.size());
      end
      send_frame(0, 1'b0);
      idle(3);
      check_windows("rstmid", 0, NW);
      n_cmp++;
      if (pq.size() == 0 || pq[0] !== 13) begin
         n_err++;
         $display("FAIL rstmid first at pixel: got %0d want 13", (pq.size() > 0) ? pq[0] : -1);
      end
   endtask

   task automatic test_signed();
      clear_q();
      send_frame(1, 1'b0);
      idle(3);
      check_windows("signed", 1, NW);
   endtask

`ifdef WINDOW_FRAME_FLAGS_EN
   task automatic test_flags();
      bit s, e;
      clear_q();
      send_frame(0, 1'b0);
      idle(3);
      for (int i = 0; i < NW; i++) begin
         s = (i < sq.size()) ? sq[i] : 1'bx;
         e = (i < eq.size()) ? eq[i] : 1'bx;
         n_cmp++;
         if (s !== (i == 0)) begin
            n_err++;
            $display("FAIL flags sof win%0d: got %b want %b", i, s, i == 0);
         end
         n_cmp++;
         if (e !== (i == NW - 1)) begin
            n_err++;
            $display("FAIL flags eof win%0d: got %b want %b", i, e, i == NW - 1);
         end
      end
      n_cmp++;
      if (flag_err !== 0) begin
         n_err++;
         $display("FAIL flags outside window: got %0d want 0", flag_err);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_continuous();
      test_gaps();
      test_back_to_back();
      test_reset_midframe();
      test_signed();
`ifdef WINDOW_FRAME_FLAGS_EN
      test_flags();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
